// File: rtl/pipeline_pkg.sv
// Shared types and default timing constants for the pipeline hazard controller.
//   ctrl_state_t : controller FSM state (RUN / EXC_PEND), 2 bits wide to match CtrlState.
//   *_DEF        : default mult/div latencies and counter width.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    EXC_PEND = 2'd1
  } ctrl_state_t;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 34;
  localparam int unsigned CNT_W_DEF       = 6;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of hazard-status inputs and stall/flush outputs between the pipeline datapath and
// the hazard controller.
//   master : datapath side, drives hazard/status signals, receives stall/flush/vector/debug.
//   slave  : controller side, receives hazard/status signals, drives stall/flush/vector/debug.
interface pipeline_hazard_ctrl_if;

  logic       IF_MemReady;
  logic       M_MemReady;
  logic       ID_LoadUse;
  logic       ID_BranchHazard;
  logic       ID_ReadsHiLo;
  logic       ID_Eret;
  logic       ID_BranchLikelyNT;
  logic       EX_MulDivStart;
  logic       EX_IsDiv;
  logic       M_Exception;

  logic       IF_Stall;
  logic       ID_Stall;
  logic       EX_Stall;
  logic       M_Stall;
  logic       IF_Flush;
  logic       ID_Flush;
  logic       EX_Flush;
  logic       M_Flush;
  logic       PC_SelVector;
  logic       MulDivBusy;
  logic [1:0] CtrlState;

  modport master (
    output IF_MemReady, M_MemReady, ID_LoadUse, ID_BranchHazard, ID_ReadsHiLo, ID_Eret,
           ID_BranchLikelyNT, EX_MulDivStart, EX_IsDiv, M_Exception,
    input  IF_Stall, ID_Stall, EX_Stall, M_Stall, IF_Flush, ID_Flush, EX_Flush, M_Flush,
           PC_SelVector, MulDivBusy, CtrlState
  );

  modport slave (
    input  IF_MemReady, M_MemReady, ID_LoadUse, ID_BranchHazard, ID_ReadsHiLo, ID_Eret,
           ID_BranchLikelyNT, EX_MulDivStart, EX_IsDiv, M_Exception,
    output IF_Stall, ID_Stall, EX_Stall, M_Stall, IF_Flush, ID_Flush, EX_Flush, M_Flush,
           PC_SelVector, MulDivBusy, CtrlState
  );

endinterface

// File: rtl/muldiv_busy_cnt.sv
// Loadable down-counter tracking the multi-cycle mult/div unit.
//   CLK      : clock, rising edge
//   RST_N    : asynchronous active-low reset, clears the counter
//   i_start  : a mult/div issues this cycle (already qualified by the EX stall)
//   i_is_div : selects the divide latency for i_start
//   o_busy   : HI/LO result not yet valid
module muldiv_busy_cnt
  import pipeline_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic i_start,
  input  logic i_is_div,
  output logic o_busy
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;

  // A start always reloads, so a restart while busy replaces the pending result timing.
  // Pipeline stalls do not hold the unit, hence no stall input here.
  always_comb begin
    w_cnt_d = r_cnt;
    if (i_start) begin
      w_cnt_d = i_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (r_cnt != '0) begin
      w_cnt_d = r_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage (IF, ID, EX, M, WB) pipeline.
//   CLK   : clock, rising edge
//   RST_N : asynchronous active-low reset; while low, all flushes assert and stalls drop
//   hz    : slave side of pipeline_hazard_ctrl_if (hazard inputs, stall/flush/vector outputs,
//           mult/div busy flag and debug FSM state)
// Stall/flush outputs are combinational so hazards take effect in the same cycle.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  pipeline_hazard_ctrl_if.slave hz
);

  ctrl_state_t r_state;
  ctrl_state_t w_state_d;

  logic w_if_stall, w_id_stall, w_ex_stall, w_m_stall;
  logic w_if_flush, w_id_flush, w_ex_flush, w_m_flush;
  logic w_pc_vec;
  logic w_busy;
  logic w_exc_evt;
  logic w_md_start;

  // In EXC_PEND the latched exception is taken without re-sampling M_Exception.
  assign w_exc_evt = (r_state == EXC_PEND) || hz.M_Exception;

  always_comb begin
    w_m_stall  = ~hz.M_MemReady;
    w_ex_stall = w_m_stall;
    w_id_stall = w_ex_stall | hz.ID_LoadUse | hz.ID_BranchHazard |
                 (hz.ID_ReadsHiLo & w_busy);
    w_if_stall = w_id_stall | ~hz.IF_MemReady;
    // Squash the delay slot only once the ERET/branch-likely actually leaves ID.
    w_if_flush = (hz.ID_Eret | hz.ID_BranchLikelyNT) & ~w_id_stall;
    // Bubble into EX while ID holds but EX moves on.
    w_id_flush = w_id_stall & ~w_ex_stall;
    w_ex_flush = 1'b0;
    w_m_flush  = 1'b0;
    w_pc_vec   = 1'b0;
    w_state_d  = r_state;

    if (!RST_N) begin
      {w_if_stall, w_id_stall, w_ex_stall, w_m_stall} = 4'b0000;
      {w_if_flush, w_id_flush, w_ex_flush, w_m_flush} = 4'b1111;
      w_state_d = RUN;
    end else if (w_exc_evt) begin
      if (hz.IF_MemReady) begin
        // Fetch has landed: flush everything and redirect to the vector.
        {w_if_stall, w_id_stall, w_ex_stall, w_m_stall} = 4'b0000;
        {w_if_flush, w_id_flush, w_ex_flush, w_m_flush} = 4'b1111;
        w_pc_vec  = 1'b1;
        w_state_d = RUN;
      end else begin
        // Freeze the pipe until the in-flight fetch completes.
        {w_if_stall, w_id_stall, w_ex_stall, w_m_stall} = 4'b1111;
        {w_if_flush, w_id_flush, w_ex_flush, w_m_flush} = 4'b0000;
        w_state_d = EXC_PEND;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Starts in an exception cycle still load the counter; the result is simply unused.
  assign w_md_start = hz.EX_MulDivStart & ~w_ex_stall;

  muldiv_busy_cnt #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_muldiv_busy_cnt (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .i_start  (w_md_start),
    .i_is_div (hz.EX_IsDiv),
    .o_busy   (w_busy)
  );

  assign hz.IF_Stall     = w_if_stall;
  assign hz.ID_Stall     = w_id_stall;
  assign hz.EX_Stall     = w_ex_stall;
  assign hz.M_Stall      = w_m_stall;
  assign hz.IF_Flush     = w_if_flush;
  assign hz.ID_Flush     = w_id_flush;
  assign hz.EX_Flush     = w_ex_flush;
  assign hz.M_Flush      = w_m_flush;
  assign hz.PC_SelVector = w_pc_vec;
  assign hz.MulDivBusy   = w_busy;
  assign hz.CtrlState    = r_state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: each stimulus cycle pushes the hand-computed
// expected output vector; a monitor on the falling edge pops and compares.
module tb_pipeline_hazard_ctrl;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;

  pipeline_hazard_ctrl_if bus ();

  pipeline_hazard_ctrl dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .hz    (bus.slave)
  );

  always #5 CLK = ~CLK;

  // Input vector {IF_MemReady, M_MemReady, LoadUse, BranchHazard, ReadsHiLo, Eret, BLNT,
  //               MulDivStart, IsDiv, M_Exception}
  localparam logic [9:0] IDLE = 10'b11_0000_0000;
  localparam logic [9:0] IFR  = 10'b10_0000_0000;
  localparam logic [9:0] MR   = 10'b01_0000_0000;
  localparam logic [9:0] LU   = 10'b00_1000_0000;
  localparam logic [9:0] BH   = 10'b00_0100_0000;
  localparam logic [9:0] HL   = 10'b00_0010_0000;
  localparam logic [9:0] ER   = 10'b00_0001_0000;
  localparam logic [9:0] BL   = 10'b00_0000_1000;
  localparam logic [9:0] MDS  = 10'b00_0000_0100;
  localparam logic [9:0] ISD  = 10'b00_0000_0010;
  localparam logic [9:0] EXC  = 10'b00_0000_0001;

  // Output vector {IF/ID/EX/M_Stall, IF/ID/EX/M_Flush, PC_SelVector, MulDivBusy, CtrlState}
  function automatic logic [11:0] ev(input logic [3:0] st, input logic [3:0] fl,
                                     input logic pcv, input logic busy, input logic [1:0] cs);
    return {st, fl, pcv, busy, cs};
  endfunction

  typedef struct {
    string       nm;
    logic [11:0] exp;
  } sb_t;

  sb_t q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic step(input string nm, input logic rst, input logic [9:0] in,
                      input logic [11:0] exp);
    sb_t e;
    @(posedge CLK);
    #1;
    RST_N = rst;
    {bus.IF_MemReady, bus.M_MemReady, bus.ID_LoadUse, bus.ID_BranchHazard, bus.ID_ReadsHiLo,
     bus.ID_Eret, bus.ID_BranchLikelyNT, bus.EX_MulDivStart, bus.EX_IsDiv,
     bus.M_Exception} = in;
    e.nm  = nm;
    e.exp = exp;
    q.push_back(e);
  endtask

  // Monitor
  initial begin
    sb_t         e;
    logic [11:0] act;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {bus.IF_Stall, bus.ID_Stall, bus.EX_Stall, bus.M_Stall,
               bus.IF_Flush, bus.ID_Flush, bus.EX_Flush, bus.M_Flush,
               bus.PC_SelVector, bus.MulDivBusy, bus.CtrlState};
        n_cmp++;
        if (act !== e.exp) begin
          n_bad++;
          $display("FAIL %s: got %b expected %b (stall4 flush4 pcv busy state2)",
                   e.nm, act, e.exp);
        end
      end
    end
  end

  initial begin
    logic [11:0] e_rst;
    logic [11:0] e_zero;
    logic [11:0] e_hilo;
    logic [11:0] e_busy;
    e_rst  = ev(4'b0000, 4'b1111, 1'b0, 1'b0, 2'd0);
    e_zero = ev(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0);
    e_hilo = ev(4'b1100, 4'b0100, 1'b0, 1'b1, 2'd0);
    e_busy = ev(4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0);

    {bus.IF_MemReady, bus.M_MemReady, bus.ID_LoadUse, bus.ID_BranchHazard, bus.ID_ReadsHiLo,
     bus.ID_Eret, bus.ID_BranchLikelyNT, bus.EX_MulDivStart, bus.EX_IsDiv,
     bus.M_Exception} = IDLE;

    step("reset", 1'b0, IDLE, e_rst);
    step("idle", 1'b1, IDLE, e_zero);

    // Load-use
    step("loaduse", 1'b1, IDLE | LU, ev(4'b1100, 4'b0100, 1'b0, 1'b0, 2'd0));
    step("loaduse_after", 1'b1, IDLE, e_zero);

    // Dmem wait, 3 cycles
    for (int i = 0; i < 3; i++) begin
      step("dmem_wait", 1'b1, IDLE & ~MR, ev(4'b1111, 4'b0000, 1'b0, 1'b0, 2'd0));
    end
    step("dmem_after", 1'b1, IDLE, e_zero);

    // Branch hazard with fetch not ready; fetch not ready alone
    step("branch_haz", 1'b1, (IDLE & ~IFR) | BH, ev(4'b1100, 4'b0100, 1'b0, 1'b0, 2'd0));
    step("ifetch_wait", 1'b1, IDLE & ~IFR, ev(4'b1000, 4'b0000, 1'b0, 1'b0, 2'd0));

    // DIV then MFHI held
    step("div_start", 1'b1, IDLE | MDS | ISD | HL, e_zero);
    for (int i = 1; i <= 34; i++) begin
      step("div_hilo_stall", 1'b1, IDLE | HL, e_hilo);
    end
    step("div_hilo_release", 1'b1, IDLE | HL, e_zero);

    // ERET blocked by load-use, then squashes the delay slot
    step("eret_loaduse", 1'b1, IDLE | ER | LU, ev(4'b1100, 4'b0100, 1'b0, 1'b0, 2'd0));
    step("eret_go", 1'b1, IDLE | ER, ev(4'b0000, 4'b1000, 1'b0, 1'b0, 2'd0));
    step("blnt", 1'b1, IDLE | BL, ev(4'b0000, 4'b1000, 1'b0, 1'b0, 2'd0));

    // Exception with fetch ready overrides dmem wait, load-use, ERET; mult still starts
    step("exc_now", 1'b1, (IDLE & ~MR) | LU | ER | MDS | EXC,
         ev(4'b0000, 4'b1111, 1'b1, 1'b0, 2'd0));
    for (int i = 0; i < 5; i++) begin
      step("exc_mult_busy", 1'b1, IDLE, e_busy);
    end
    step("exc_mult_done", 1'b1, IDLE, e_zero);

    // Exception during fetch
    step("exc_pend_t0", 1'b1, (IDLE & ~IFR) | EXC, ev(4'b1111, 4'b0000, 1'b0, 1'b0, 2'd0));
    step("exc_pend_t1", 1'b1, IDLE & ~IFR, ev(4'b1111, 4'b0000, 1'b0, 1'b0, 2'd1));
    step("exc_pend_t2", 1'b1, IDLE & ~IFR, ev(4'b1111, 4'b0000, 1'b0, 1'b0, 2'd1));
    step("exc_pend_t3", 1'b1, IDLE, ev(4'b0000, 4'b1111, 1'b1, 1'b0, 2'd1));
    step("exc_pend_t4", 1'b1, IDLE, e_zero);

    // Restart: MULT then DIV reloads the counter past the mult latency
    step("restart_mult", 1'b1, IDLE | MDS, e_zero);
    step("restart_busy", 1'b1, IDLE, e_busy);
    step("restart_div", 1'b1, IDLE | MDS | ISD, e_busy);
    for (int i = 0; i < 6; i++) begin
      step("restart_still_busy", 1'b1, IDLE, e_busy);
    end

    // Reset during EXC_PEND
    step("rpend_t0", 1'b1, (IDLE & ~IFR) | EXC, ev(4'b1111, 4'b0000, 1'b0, 1'b1, 2'd0));
    step("rpend_t1", 1'b1, IDLE & ~IFR, ev(4'b1111, 4'b0000, 1'b0, 1'b1, 2'd1));
    step("rpend_reset", 1'b0, IDLE & ~IFR, e_rst);
    step("rpend_run", 1'b1, IDLE, e_zero);
    step("rpend_cnt_clear", 1'b1, IDLE | HL, e_zero);

    // Drain scoreboard with a bound
    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      @(posedge CLK);
    end
    @(posedge CLK);
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, M, WB).
- Drives the Stall/Flush inputs of every inter-stage pipeline register, including the IF/ID register.
- Tracks the multi-cycle mult/div unit so HI/LO readers stall until the result is ready.
- Sequences exception redirect so an in-flight instruction fetch completes before the flush and vector load.

Parameters:
- MULT_CYCLES, 5: busy cycles after a MULT/MULTU issue.
- DIV_CYCLES, 34: busy cycles after a DIV/DIVU issue.
- CNT_W, 6: mult/div counter width. Must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  reset, asynchronous assert, active-low.
- IF_MemReady  in  1  instruction fetch completes this cycle.
- M_MemReady  in  1  data access completes this cycle (1 when M has no access).
- ID_LoadUse  in  1  ID instruction needs a load result currently in EX.
- ID_BranchHazard  in  1  ID branch operand not yet available from EX/M.
- ID_ReadsHiLo  in  1  ID holds MFHI/MFLO.
- ID_Eret  in  1  ID holds ERET.
- ID_BranchLikelyNT  in  1  ID holds a not-taken Branch Likely.
- EX_MulDivStart  in  1  EX holds a mult/div.
- EX_IsDiv  in  1  qualifies EX_MulDivStart.
- M_Exception  in  1  M instruction raises an exception.
- IF_Stall, ID_Stall, EX_Stall, M_Stall  out  1 each  stall to the corresponding pipeline register.
- IF_Flush, ID_Flush, EX_Flush, M_Flush  out  1 each  bubble into the next stage.
- PC_SelVector  out  1  PC loads the exception vector this cycle.
- MulDivBusy  out  1  HI/LO result not yet valid.
- CtrlState  out  2  current FSM state, for debug.

Behaviour:
- State: FSM {RUN=0, EXC_PEND=1}; counter mdcnt[CNT_W-1:0].
- Reset: while RST_N=0, state=RUN and mdcnt=0. Outputs: all Stall=0, all Flush=1, PC_SelVector=0, MulDivBusy=0.
- Mult/div counter:
  - Loads on EX_MulDivStart & ~EX_Stall: DIV_CYCLES if EX_IsDiv, else MULT_CYCLES.
  - Otherwise decrements each cycle if nonzero. Stalls do not gate the decrement.
  - A new start while busy reloads the counter (restart).
  - MulDivBusy = (mdcnt != 0).
- Stall chain in RUN, no exception (combinational, zero latency):
  - M_Stall = ~M_MemReady.
  - EX_Stall = M_Stall.
  - ID_Stall = EX_Stall | ID_LoadUse | ID_BranchHazard | (ID_ReadsHiLo & MulDivBusy).
  - IF_Stall = ID_Stall | ~IF_MemReady.
- Flushes in RUN, no exception:
  - IF_Flush = (ID_Eret | ID_BranchLikelyNT) & ~ID_Stall. This squashes the delay slot.
  - ID_Flush = ID_Stall & ~EX_Stall. This inserts a bubble into EX while ID holds.
  - EX_Flush = 0; M_Flush = 0.
- Exception in RUN with IF_MemReady=1, cycle T:
  - IF/ID/EX/M_Flush = 1, PC_SelVector = 1, all Stall = 0.
  - This overrides M_MemReady=0 and every hazard input.
  - State stays RUN.
- Exception in RUN with IF_MemReady=0:
  - Go to EXC_PEND. Flushes = 0 and all Stall = 1 in that cycle.
- EXC_PEND:
  - All Stall = 1, Flushes = 0, PC_SelVector = 0.
  - M_Exception is not re-sampled; the latched event is taken.
  - Leave when IF_MemReady=1. That cycle performs the exception action above, then the FSM returns to RUN.
  - Worst case: unbounded, until the fetch completes.
- Simultaneous events:
  - Exception beats ERET/branch-likely flush, load-use and HI/LO stall.
  - EX_MulDivStart in an exception cycle with EX_Flush=1 still starts the counter; the counter is harmless.
- Reset mid-operation: an asynchronous RST_N drop aborts EXC_PEND and the counter immediately.

Decomposition:
- Shared package pipeline_pkg: ctrl_state_t enum {RUN, EXC_PEND}, MULT_CYCLES/DIV_CYCLES defaults.
- Sub-module muldiv_busy_cnt holds the loadable down-counter with the busy flag. Everything else stays in the top module.

Test Plan:
- Load-use: ID_LoadUse=1 for 1 cycle, memories ready -> ID_Stall=1, IF_Stall=1, ID_Flush=1, EX_Stall=0 that cycle; all 0 the next.
- DIV then MFHI: EX_MulDivStart=1, EX_IsDiv=1 at T0; ID_ReadsHiLo held -> ID_Stall=1 for T1..T34, released T35; MulDivBusy falls at T35.
- Dmem wait: M_MemReady=0 for 3 cycles -> M/EX/ID/IF_Stall=1 for exactly those 3 cycles, Flushes=0.
- Exception during fetch: M_Exception=1 at T0, IF_MemReady=0 for T0..T2, 1 at T3 -> CtrlState=1 for T1..T3, all Stall=1 in T0..T2, at T3 all Flush=1 and PC_SelVector=1, back in RUN at T4.
- ERET with load-use: ID_Eret=1, ID_LoadUse=1 at T0, then ID_LoadUse=0 at T1 -> IF_Flush=0 at T0, IF_Flush=1 at T1.
- Reset during EXC_PEND: RST_N low mid-pend -> CtrlState=0, MulDivBusy=0, all Flush=1 asynchronously; first cycle after release behaves as RUN.
